i2so_lr_sched: RTL and testbench

I2SO_LR_SCHED -- requirements
Module: i2so_lr_sched

---
 rtl/i2so_lr_sched.sv | 127 ++++++++++++
 tb/tb_i2so_lr_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2so_lr_sched.sv
// I2S output left/right pair scheduler: serial clock divider plus an FSM that pulls
// left then right samples into the i2s_out FIFO, zero-filling a right sample that never arrives.
module i2so_lr_sched #(
    parameter int CYC_PER_HALF_SCK = 40,
    parameter int PAIR_TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sched_en,
    input  logic        left_rts,
    input  logic [31:0] left_data,
    output logic        left_rtr,
    input  logic        right_rts,
    input  logic [31:0] right_data,
    output logic        right_rtr,
    input  logic        filt_rtr,
    output logic        filt_rts,
    output logic [31:0] filt_data,
    output logic        sck,
    output logic        sck_transition,
    input  logic        trig_pair_timeout,
    output logic        ro_pair_timeout,
    output logic [15:0] pair_cnt
);

    localparam logic [7:0] DIV_LAST = 8'(CYC_PER_HALF_SCK - 1);
    localparam logic [7:0] TO_LIMIT = 8'(PAIR_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_L,
        PUSH_L,
        WAIT_R,
        PUSH_R,
        PUSH_Z
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic [7:0]  to_cnt;
    logic        div_last;
    logic        left_xfer;
    logic        right_xfer;

    assign div_last   = (div_cnt == DIV_LAST);
    assign left_xfer  = left_rts & left_rtr;
    assign right_xfer = right_rts & right_rtr;

    // Free-running divider; sck_transition marks the first cycle sck reads high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt        <= 8'd0;
            sck            <= 1'b0;
            sck_transition <= 1'b0;
        end else begin
            sck_transition <= div_last & ~sck;
            if (div_last) begin
                div_cnt <= 8'd0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        left_rtr  = 1'b0;
        right_rtr = 1'b0;
        filt_rts  = 1'b0;
        case (state)
            IDLE: begin
                if (sched_en) state_nxt = WAIT_L;
            end
            WAIT_L: begin
                left_rtr = filt_rtr & sched_en;
                if (left_rts & filt_rtr & sched_en) state_nxt = PUSH_L;
                else if (!sched_en)                 state_nxt = IDLE;
            end
            PUSH_L: begin
                filt_rts  = 1'b1;
                state_nxt = WAIT_R;
            end
            WAIT_R: begin
                // A right sample arriving on the timeout cycle still wins over zero-fill.
                right_rtr = filt_rtr & sched_en;
                if (right_rts & filt_rtr & sched_en) state_nxt = PUSH_R;
                else if (!sched_en)                  state_nxt = IDLE;
                else if (to_cnt == TO_LIMIT)         state_nxt = PUSH_Z;
            end
            PUSH_R, PUSH_Z: begin
                filt_rts  = 1'b1;
                state_nxt = WAIT_L;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            to_cnt          <= 8'd0;
            filt_data       <= 32'd0;
            ro_pair_timeout <= 1'b0;
            pair_cnt        <= 16'd0;
        end else begin
            state <= state_nxt;

            if (left_xfer)                filt_data <= left_data;
            else if (right_xfer)          filt_data <= right_data;
            else if (state_nxt == PUSH_Z) filt_data <= 32'd0;

            if (state == PUSH_L)
                to_cnt <= 8'd0;
            else if (state == WAIT_R && sck_transition && to_cnt < TO_LIMIT)
                to_cnt <= to_cnt + 8'd1;

            if (state == PUSH_R || state == PUSH_Z)
                pair_cnt <= pair_cnt + 16'd1;

            if (state == PUSH_Z)        ro_pair_timeout <= 1'b1;
            else if (trig_pair_timeout) ro_pair_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2so_lr_sched.sv
// Directed testbench for i2so_lr_sched at default parameters (40 clk per sck half, 64 sck timeout).
module tb_i2so_lr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sched_en = 1'b0;
    logic        left_rts = 1'b0;
    logic [31:0] left_data = 32'd0;
    logic        left_rtr;
    logic        right_rts = 1'b0;
    logic [31:0] right_data = 32'd0;
    logic        right_rtr;
    logic        filt_rtr = 1'b0;
    logic        filt_rts;
    logic [31:0] filt_data;
    logic        sck;
    logic        sck_transition;
    logic        trig_pair_timeout = 1'b0;
    logic        ro_pair_timeout;
    logic [15:0] pair_cnt;

    int checks = 0;
    int passes = 0;

    i2so_lr_sched dut (
        .clk               (clk),
        .rst               (rst),
        .sched_en          (sched_en),
        .left_rts          (left_rts),
        .left_data         (left_data),
        .left_rtr          (left_rtr),
        .right_rts         (right_rts),
        .right_data        (right_data),
        .right_rtr         (right_rtr),
        .filt_rtr          (filt_rtr),
        .filt_rts          (filt_rts),
        .filt_data         (filt_data),
        .sck               (sck),
        .sck_transition    (sck_transition),
        .trig_pair_timeout (trig_pair_timeout),
        .ro_pair_timeout   (ro_pair_timeout),
        .pair_cnt          (pair_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called in WAIT_L; returns at the negedge of the PUSH_L cycle.
    task automatic push_left(input logic [31:0] d);
        left_rts  = 1'b1;
        left_data = d;
        @(negedge clk);
        left_rts  = 1'b0;
    endtask

    task automatic test_reset();
        sched_en = 1'b1; filt_rtr = 1'b1; left_rts = 1'b1; right_rts = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sck !== 1'b0) $display("[TB] FAIL rst_sck: got %b want 0", sck); else passes++;
        checks++; if (sck_transition !== 1'b0) $display("[TB] FAIL rst_sck_tr: got %b want 0", sck_transition); else passes++;
        checks++; if (filt_rts !== 1'b0) $display("[TB] FAIL rst_filt_rts: got %b want 0", filt_rts); else passes++;
        checks++; if (filt_data !== 32'd0) $display("[TB] FAIL rst_filt_data: got %h want 0", filt_data); else passes++;
        checks++; if (pair_cnt !== 16'd0) $display("[TB] FAIL rst_pair_cnt: got %h want 0", pair_cnt); else passes++;
        checks++; if (ro_pair_timeout !== 1'b0) $display("[TB] FAIL rst_ro: got %b want 0", ro_pair_timeout); else passes++;
        checks++; if (left_rtr !== 1'b0) $display("[TB] FAIL rst_left_rtr: got %b want 0", left_rtr); else passes++;
        checks++; if (right_rtr !== 1'b0) $display("[TB] FAIL rst_right_rtr: got %b want 0", right_rtr); else passes++;
        sched_en = 1'b0; filt_rtr = 1'b0; left_rts = 1'b0; right_rts = 1'b0;
    endtask

    // After k rising edges since release: sck = (k/40) odd, pulse when k mod 80 == 40.
    task automatic test_divider();
        logic exp_sck;
        logic exp_tr;
        rst = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            exp_sck = ((k / 40) % 2) == 1;
            exp_tr  = (k % 80) == 40;
            checks++; if (sck !== exp_sck) $display("[TB] FAIL div_sck k=%0d: got %b want %b", k, sck, exp_sck); else passes++;
            checks++; if (sck_transition !== exp_tr) $display("[TB] FAIL div_sck_tr k=%0d: got %b want %b", k, sck_transition, exp_tr); else passes++;
        end
    endtask

    task automatic test_pair();
        sched_en = 1'b1; filt_rtr = 1'b1;
        @(negedge clk);
        checks++; if (left_rtr !== 1'b1) $display("[TB] FAIL pair_wl_left_rtr: got %b want 1", left_rtr); else passes++;
        checks++; if (right_rtr !== 1'b0) $display("[TB] FAIL pair_wl_right_rtr: got %b want 0", right_rtr); else passes++;
        push_left(32'hFFFF_FFFF);
        checks++; if (filt_rts !== 1'b1) $display("[TB] FAIL pair_pl_rts: got %b want 1", filt_rts); else passes++;
        checks++; if (filt_data !== 32'hFFFF_FFFF) $display("[TB] FAIL pair_pl_data: got %h want ffffffff", filt_data); else passes++;
        checks++; if ({left_rtr, right_rtr} !== 2'b00) $display("[TB] FAIL pair_pl_rtrs: got %b want 00", {left_rtr, right_rtr}); else passes++;
        @(negedge clk);
        checks++; if (filt_rts !== 1'b0) $display("[TB] FAIL pair_wr_rts: got %b want 0", filt_rts); else passes++;
        checks++; if (filt_data !== 32'hFFFF_FFFF) $display("[TB] FAIL pair_wr_hold: got %h want ffffffff", filt_data); else passes++;
        checks++; if ({left_rtr, right_rtr} !== 2'b01) $display("[TB] FAIL pair_wr_rtrs: got %b want 01", {left_rtr, right_rtr}); else passes++;
        right_rts = 1'b1; right_data = 32'hAAAA_AAAA;
        @(negedge clk);
        right_rts = 1'b0;
        checks++; if (filt_rts !== 1'b1) $display("[TB] FAIL pair_pr_rts: got %b want 1", filt_rts); else passes++;
        checks++; if (filt_data !== 32'hAAAA_AAAA) $display("[TB] FAIL pair_pr_data: got %h want aaaaaaaa", filt_data); else passes++;
        @(negedge clk);
        checks++; if (filt_rts !== 1'b0) $display("[TB] FAIL pair_end_rts: got %b want 0", filt_rts); else passes++;
        checks++; if (pair_cnt !== 16'd1) $display("[TB] FAIL pair_cnt: got %0d want 1", pair_cnt); else passes++;
    endtask

    task automatic test_order();
        right_rts = 1'b1; right_data = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (right_rtr !== 1'b0) $display("[TB] FAIL order_right_rtr i=%0d: got %b want 0", i, right_rtr); else passes++;
            checks++; if (filt_rts !== 1'b0) $display("[TB] FAIL order_no_write i=%0d: got %b want 0", i, filt_rts); else passes++;
        end
        push_left(32'h1111_1111);
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'h1111_1111) $display("[TB] FAIL order_left_first: got rts=%b data=%h want rts=1 data=11111111", filt_rts, filt_data); else passes++;
        @(negedge clk);
        @(negedge clk);
        right_rts = 1'b0;
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'h1234_5678) $display("[TB] FAIL order_right: got rts=%b data=%h want rts=1 data=12345678", filt_rts, filt_data); else passes++;
        @(negedge clk);
        checks++; if (pair_cnt !== 16'd2) $display("[TB] FAIL order_pair_cnt: got %0d want 2", pair_cnt); else passes++;
    endtask

    task automatic test_backpressure();
        filt_rtr = 1'b0; left_rts = 1'b1; left_data = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({left_rtr, right_rtr, filt_rts} !== 3'b000) $display("[TB] FAIL bp_wl i=%0d: got rtrs/rts=%b want 000", i, {left_rtr, right_rtr, filt_rts}); else passes++;
        end
        filt_rtr = 1'b1;
        @(negedge clk);
        left_rts = 1'b0;
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'h2222_2222) $display("[TB] FAIL bp_left: got rts=%b data=%h want rts=1 data=22222222", filt_rts, filt_data); else passes++;
        filt_rtr = 1'b0; right_rts = 1'b1; right_data = 32'h3333_3333;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({left_rtr, right_rtr, filt_rts} !== 3'b000) $display("[TB] FAIL bp_wr i=%0d: got rtrs/rts=%b want 000", i, {left_rtr, right_rtr, filt_rts}); else passes++;
        end
        filt_rtr = 1'b1;
        @(negedge clk);
        right_rts = 1'b0;
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'h3333_3333) $display("[TB] FAIL bp_right: got rts=%b data=%h want rts=1 data=33333333", filt_rts, filt_data); else passes++;
        @(negedge clk);
        checks++; if (pair_cnt !== 16'd3) $display("[TB] FAIL bp_pair_cnt: got %0d want 3", pair_cnt); else passes++;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        bit seen = 0;
        push_left(32'h0BAD_CAFE);
        filt_rtr = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (filt_rts) seen = 1;
            else if (sck_transition) pulses++;
            if (i == 1000) filt_rtr = 1'b1;
        end
        filt_rtr = 1'b1;
        checks++; if (seen !== 1'b1) $display("[TB] FAIL to_write_seen: got %b want 1", seen); else passes++;
        checks++; if (pulses != 64) $display("[TB] FAIL to_sck_edges: got %0d want 64", pulses); else passes++;
        checks++; if (filt_data !== 32'd0) $display("[TB] FAIL to_zero_data: got %h want 0", filt_data); else passes++;
        @(negedge clk);
        checks++; if (ro_pair_timeout !== 1'b1) $display("[TB] FAIL to_ro_set: got %b want 1", ro_pair_timeout); else passes++;
        checks++; if (pair_cnt !== 16'd4) $display("[TB] FAIL to_pair_cnt: got %0d want 4", pair_cnt); else passes++;
        trig_pair_timeout = 1'b1;
        @(negedge clk);
        trig_pair_timeout = 1'b0;
        checks++; if (ro_pair_timeout !== 1'b0) $display("[TB] FAIL to_ro_clear: got %b want 0", ro_pair_timeout); else passes++;
    endtask

    // Right sample offered on the very cycle the timeout count is reached.
    task automatic test_transfer_wins();
        int pulses = 0;
        bit early = 0;
        push_left(32'h4444_4444);
        for (int i = 0; i < 6000 && pulses < 64; i++) begin
            @(negedge clk);
            if (filt_rts) early = 1;
            if (sck_transition) pulses++;
        end
        checks++; if (pulses != 64 || early) $display("[TB] FAIL tw_wait: got pulses=%0d early=%b want 64/0", pulses, early); else passes++;
        @(negedge clk);
        checks++; if (filt_rts !== 1'b0) $display("[TB] FAIL tw_pre: got %b want 0", filt_rts); else passes++;
        right_rts = 1'b1; right_data = 32'hC0FF_EE00;
        @(negedge clk);
        right_rts = 1'b0;
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'hC0FF_EE00) $display("[TB] FAIL tw_right: got rts=%b data=%h want rts=1 data=c0ffee00", filt_rts, filt_data); else passes++;
        @(negedge clk);
        checks++; if (ro_pair_timeout !== 1'b0) $display("[TB] FAIL tw_ro: got %b want 0", ro_pair_timeout); else passes++;
        checks++; if (pair_cnt !== 16'd5) $display("[TB] FAIL tw_pair_cnt: got %0d want 5", pair_cnt); else passes++;
    endtask

    task automatic test_set_clear_collision();
        bit seen = 0;
        push_left(32'h5555_5555);
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (filt_rts) seen = 1;
        end
        checks++; if (seen !== 1'b1 || filt_data !== 32'd0) $display("[TB] FAIL col_zero_write: got seen=%b data=%h want 1/0", seen, filt_data); else passes++;
        trig_pair_timeout = 1'b1;
        @(negedge clk);
        trig_pair_timeout = 1'b0;
        checks++; if (ro_pair_timeout !== 1'b1) $display("[TB] FAIL col_set_wins: got %b want 1", ro_pair_timeout); else passes++;
        @(negedge clk);
        checks++; if (ro_pair_timeout !== 1'b1) $display("[TB] FAIL col_sticky: got %b want 1", ro_pair_timeout); else passes++;
        checks++; if (pair_cnt !== 16'd6) $display("[TB] FAIL col_pair_cnt: got %0d want 6", pair_cnt); else passes++;
    endtask

    task automatic test_wrap();
        force dut.pair_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.pair_cnt;
        checks++; if (pair_cnt !== 16'hFFFF) $display("[TB] FAIL wrap_preload: got %h want ffff", pair_cnt); else passes++;
        push_left(32'h6666_6666);
        @(negedge clk);
        right_rts = 1'b1; right_data = 32'h7777_7777;
        @(negedge clk);
        right_rts = 1'b0;
        checks++; if (pair_cnt !== 16'hFFFF) $display("[TB] FAIL wrap_during_push: got %h want ffff", pair_cnt); else passes++;
        @(negedge clk);
        checks++; if (pair_cnt !== 16'h0000) $display("[TB] FAIL wrap_zero: got %h want 0000", pair_cnt); else passes++;
    endtask

    task automatic test_disable();
        push_left(32'h8888_8888);
        sched_en = 1'b0;
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'h8888_8888) $display("[TB] FAIL dis_push_completes: got rts=%b data=%h want 1/88888888", filt_rts, filt_data); else passes++;
        @(negedge clk);
        checks++; if ({right_rtr, filt_rts} !== 2'b00) $display("[TB] FAIL dis_wr: got rtr/rts=%b want 00", {right_rtr, filt_rts}); else passes++;
        right_rts = 1'b1; right_data = 32'h9999_9999;
        repeat (2) @(negedge clk);
        checks++; if ({left_rtr, right_rtr, filt_rts} !== 3'b000) $display("[TB] FAIL dis_idle: got %b want 000", {left_rtr, right_rtr, filt_rts}); else passes++;
        sched_en = 1'b1;
        @(negedge clk);
        checks++; if ({left_rtr, right_rtr} !== 2'b10) $display("[TB] FAIL dis_restart_wl: got %b want 10", {left_rtr, right_rtr}); else passes++;
        push_left(32'hABCD_EF01);
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'hABCD_EF01) $display("[TB] FAIL dis_left_first: got rts=%b data=%h want 1/abcdef01", filt_rts, filt_data); else passes++;
        @(negedge clk);
        @(negedge clk);
        right_rts = 1'b0;
        checks++; if (filt_rts !== 1'b1 || filt_data !== 32'h9999_9999) $display("[TB] FAIL dis_right: got rts=%b data=%h want 1/99999999", filt_rts, filt_data); else passes++;
        @(negedge clk);
        checks++; if (pair_cnt !== 16'd1) $display("[TB] FAIL dis_pair_cnt: got %0d want 1", pair_cnt); else passes++;
    endtask

    task automatic test_reset_midframe();
        bit seen = 0;
        logic [31:0] first;
        push_left(32'hDEAD_BEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({filt_rts, sck, sck_transition, ro_pair_timeout} !== 4'b0000) $display("[TB] FAIL mid_rst_bits: got rts/sck/tr/ro=%b want 0000", {filt_rts, sck, sck_transition, ro_pair_timeout}); else passes++;
        checks++; if (filt_data !== 32'd0) $display("[TB] FAIL mid_rst_data: got %h want 0", filt_data); else passes++;
        checks++; if (pair_cnt !== 16'd0) $display("[TB] FAIL mid_rst_pair_cnt: got %0d want 0", pair_cnt); else passes++;
        checks++; if ({left_rtr, right_rtr} !== 2'b00) $display("[TB] FAIL mid_rst_rtrs: got %b want 00", {left_rtr, right_rtr}); else passes++;
        @(negedge clk);
        rst = 1'b0;
        left_rts = 1'b1; left_data = 32'h5A5A_5A5A;
        right_rts = 1'b1; right_data = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        checks++; if (filt_rts !== 1'b1) $display("[TB] FAIL mid_push_before_rst: got %b want 1", filt_rts); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (filt_rts !== 1'b0) $display("[TB] FAIL mid_push_abort: got %b want 0", filt_rts); else passes++;
        @(negedge clk);
        rst = 1'b0;
        first = 32'd0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (filt_rts) begin
                seen  = 1;
                first = filt_data;
            end
        end
        left_rts = 1'b0; right_rts = 1'b0;
        checks++; if (seen !== 1'b1 || first !== 32'h5A5A_5A5A) $display("[TB] FAIL mid_first_left: got seen=%b data=%h want 1/5a5a5a5a", seen, first); else passes++;
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_divider();
        test_pair();
        test_order();
        test_backpressure();
        test_timeout();
        test_transfer_wins();
        test_set_clear_collision();
        test_wrap();
        test_disable();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
